axis_stream_tx_fifo: RTL and testbench
======================================

# axis_stream_tx_fifo

Parametrised AXI4-Stream master transmitter for the SHA3 datapath, successor to the single-beat stream transmitter. It accepts raw data beats from the core over a valid/ready interface and buffers them in a FIFO_DEPTH-entry FIFO. It then drives a standards-compliant AXI-Stream master port. Packets are framed by a programmable beat count with a partial final beat, so TLAST and TKEEP/TSTRB are generated internally rather than supplied by the core.

## Interface
- DATA_WIDTH, 64, TDATA width; multiple of 8, ≥ 8
- ID_WIDTH, 8, TID width
- USER_WIDTH, 2, TUSER width
- FIFO_DEPTH, 4, buffer entries; power of 2, ≥ 2
- LEN_WIDTH, 16, width of packet beat count
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- in_valid  in  1  core beat valid
- in_ready  out  1  core beat accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  core beat data
- pkt_beats  in  LEN_WIDTH  beats per packet; sampled on first beat of a packet; 0 treated as 1
- last_bytes  in  $clog2(DATA_WIDTH/8)+1  valid bytes in final beat; sampled with pkt_beats; 0 or > DATA_WIDTH/8 treated as full
- pkt_id  in  ID_WIDTH  TID for the packet; sampled with pkt_beats
- pkt_user  in  USER_WIDTH  TUSER for the packet; sampled with pkt_beats
- flush  in  1  synchronous clear of FIFO and framing state
- TVALID  out  1  master valid
- TREADY  in  1  slave ready
- TDATA  out  DATA_WIDTH  beat data
- TKEEP  out  DATA_WIDTH/8  byte qualifiers
- TSTRB  out  DATA_WIDTH/8  always equal to TKEEP
- TLAST  out  1  final beat of packet
- TID  out  ID_WIDTH  packet ID
- TUSER  out  USER_WIDTH  packet user bits
- in_pkt  out  1  write side is mid-packet

## Operation
- Write-side FSM:
  - IDLE: on an accepted beat, latch pkt_beats, last_bytes, pkt_id and pkt_user. Set beat_cnt = 1. Go to IN_PKT, unless the effective length is 1, in which case stay in IDLE.
  - IN_PKT: each accepted beat increments beat_cnt. The beat where beat_cnt == effective length - 1 before increment is the last; return to IDLE.
- FIFO entry = {data, keep, last, id, user}, all computed at write time.
  - keep = all ones on non-final beats.
  - On the final beat, keep = (1 << bytes) - 1, LSB-aligned.
  - The single-beat packet case uses the live inputs for keep, last, id and user.
- in_ready = !full. There is no combinational path from TREADY to in_ready.
- A simultaneous write and read while neither full nor empty keeps count unchanged.
- Read side: TVALID = !empty, and TDATA, TKEEP, TLAST, TID and TUSER come from the head entry. On TVALID && TREADY, pop the head entry.
- AXI rule: once TVALID is high, TVALID and all payload fields hold until the handshake. flush is the only exception.
- Pointers have $clog2(FIFO_DEPTH)+1 bits; full/empty are decided from the wrap bit and wrap naturally at depth.
- flush: next edge empties the FIFO, returns the FSM to IDLE and drops TVALID. flush has priority over simultaneous writes and reads; neither beat is stored or counted.

## Timing
- Reset (ARESETn low, asynchronous):
  - Cleared: TVALID, TLAST, TKEEP, TSTRB, TDATA, TID, TUSER, in_pkt, pointers and beat_cnt all 0; FSM in IDLE.
  - in_ready = 1 from the first cycle after deassertion.
- Reset asserted mid-packet discards all buffered beats; the partial packet is never completed.
- Latency: a beat accepted at edge N appears with TVALID = 1 after edge N when the FIFO was empty.
- Throughput: 1 beat/cycle sustained with TREADY held high.
- When full, in_ready = 0 for the whole cycle, even if a pop occurs on that edge. in_ready rises the cycle after the pop.

## Configuration
- AXIS_TX_STATS_EN defined: adds the following ports; both counters clear on reset and flush:
  - pkt_count  out  32: increments on each TVALID && TREADY && TLAST, wrapping at 2^32.
  - stall_count  out  32: increments on each cycle with TVALID && !TREADY, saturating at 2^32-1.
- AXIS_TX_STATS_EN undefined: both ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset: ARESETn=0 mid-stream with 3 beats buffered -> TVALID=0 and all outputs 0 immediately; in_ready=1 after release.
- Framing: DATA_WIDTH=64, pkt_beats=3, last_bytes=5, pkt_id=8'h2A, TREADY=1, data 1,2,3 -> TLAST only on beat 3 with TKEEP=8'h1F, beats 1-2 TKEEP=8'hFF, TID=8'h2A on all, TSTRB==TKEEP.
- Single-beat and zero length: pkt_beats=0 then pkt_beats=1, last_bytes=0 -> each beat has TLAST=1 and TKEEP=8'hFF; FSM stays IDLE.
- Backpressure: TREADY=0, push 5 beats at FIFO_DEPTH=4 -> in_ready=0 after 4th; TDATA/TVALID stable; releasing TREADY delivers all 5 in order, none lost; with stats, stall_count equals stalled cycles.
- Flush: flush with 2 beats queued and in_valid=1 -> next cycle TVALID=0, in_pkt=0; the next packet starts fresh with newly sampled pkt_beats.
- Stats (AXIS_TX_STATS_EN): 4 packets of 2 beats with TREADY=1 -> pkt_count=4; macro undefined -> module elaborates without the counter ports.

Source files
------------

// File: rtl/axis_stream_tx_fifo_if.sv
// AXI4-Stream bus between axis_stream_tx_fifo (master) and its downstream consumer (slave).
interface axis_stream_tx_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2
) ();
  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic [DATA_WIDTH/8-1:0] TSTRB;
  logic                    TLAST;
  logic [ID_WIDTH-1:0]     TID;
  logic [USER_WIDTH-1:0]   TUSER;

  modport master (
    output TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TUSER,
    input  TREADY
  );

  modport slave (
    input  TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TUSER,
    output TREADY
  );
endinterface

// File: rtl/axis_stream_tx_fifo.sv
// AXI4-Stream transmitter: buffers core beats in a FIFO and frames packets (TLAST/TKEEP) internally.
// Define AXIS_TX_STATS_EN to add the pkt_count / stall_count statistics ports.
module axis_stream_tx_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16,
  localparam int KEEP_W    = DATA_WIDTH / 8,
  localparam int LB_W      = $clog2(KEEP_W) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]  pkt_beats,
  input  logic [LB_W-1:0]       last_bytes,
  input  logic [ID_WIDTH-1:0]   pkt_id,
  input  logic [USER_WIDTH-1:0] pkt_user,
  input  logic                  flush,
  output logic                  in_pkt,
`ifdef AXIS_TX_STATS_EN
  output logic [31:0]           pkt_count,
  output logic [31:0]           stall_count,
`endif
  axis_stream_tx_fifo_if.master m_axis
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;
  localparam logic [LB_W-1:0] FULL_BYTES = LB_W'(KEEP_W);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]     keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [USER_WIDTH-1:0] user;
  } entry_t;

  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [0:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d, len_q, len_d;
  logic [LB_W-1:0]       bytes_q, bytes_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  logic                  full, empty, wr_en, rd_en, final_beat;
  logic [LEN_WIDTH-1:0]  live_len;
  logic [LB_W-1:0]       live_bytes, final_bytes;
  entry_t                wr_entry, head;

  function automatic logic [KEEP_W-1:0] bytes_to_keep(input logic [LB_W-1:0] n);
    logic [KEEP_W-1:0] k;
    k = '0;
    for (int i = 0; i < KEEP_W; i++) k[i] = (LB_W'(i) < n);
    return k;
  endfunction

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign wr_en = in_valid && !full && !flush;
  assign rd_en = !empty && m_axis.TREADY && !flush;

  // Zero length means one beat; out-of-range byte counts mean a full final beat.
  assign live_len   = (pkt_beats == '0) ? LEN_WIDTH'(1) : pkt_beats;
  assign live_bytes = ((last_bytes == '0) || (last_bytes > FULL_BYTES)) ? FULL_BYTES : last_bytes;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    len_d         = len_q;
    bytes_d       = bytes_q;
    id_d          = id_q;
    user_d        = user_q;
    final_beat    = 1'b0;
    final_bytes   = bytes_q;
    wr_entry.data = in_data;
    wr_entry.id   = id_q;
    wr_entry.user = user_q;
    if (state_q == ST_IDLE) begin
      final_beat    = (live_len == LEN_WIDTH'(1));
      final_bytes   = live_bytes;
      wr_entry.id   = pkt_id;
      wr_entry.user = pkt_user;
    end else begin
      final_beat = (beat_cnt_q == len_q - LEN_WIDTH'(1));
    end
    wr_entry.keep = final_beat ? bytes_to_keep(final_bytes) : '1;
    wr_entry.last = final_beat;

    if (flush) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
    end else if (wr_en) begin
      if (state_q == ST_IDLE) begin
        len_d      = live_len;
        bytes_d    = live_bytes;
        id_d       = pkt_id;
        user_d     = pkt_user;
        beat_cnt_d = LEN_WIDTH'(1);
        state_d    = final_beat ? ST_IDLE : ST_IN_PKT;
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
        if (final_beat) state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_entry;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      len_q      <= '0;
      bytes_q    <= '0;
      id_q       <= '0;
      user_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      bytes_q    <= bytes_d;
      id_q       <= id_d;
      user_q     <= user_d;
    end
  end

  // Payload is read straight from the head entry, so it cannot change until the pop.
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign in_ready      = !full;
  assign in_pkt        = (state_q == ST_IN_PKT);
  assign m_axis.TVALID = !empty;
  assign m_axis.TDATA  = head.data;
  assign m_axis.TKEEP  = head.keep;
  assign m_axis.TSTRB  = head.keep;
  assign m_axis.TLAST  = head.last;
  assign m_axis.TID    = head.id;
  assign m_axis.TUSER  = head.user;

`ifdef AXIS_TX_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d, stall_count_q, stall_count_d;

  always_comb begin
    pkt_count_d   = pkt_count_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      pkt_count_d   = '0;
      stall_count_d = '0;
    end else begin
      if (rd_en && head.last) pkt_count_d = pkt_count_q + 32'd1;
      if (!empty && !m_axis.TREADY && (stall_count_q != '1)) stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_axis_stream_tx_fifo.sv
// Scoreboard testbench for axis_stream_tx_fifo (64-bit data, depth 4); also exercises
// the statistics ports when built with AXIS_TX_STATS_EN defined.
module tb_axis_stream_tx_fifo;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [1:0]  user;
  } beat_t;

  logic        ACLK;
  logic        ARESETn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [15:0] pkt_beats;
  logic [3:0]  last_bytes;
  logic [7:0]  pkt_id;
  logic [1:0]  pkt_user;
  logic        flush;
  logic        in_pkt;
`ifdef AXIS_TX_STATS_EN
  logic [31:0] pkt_count;
  logic [31:0] stall_count;
`endif

  axis_stream_tx_fifo_if #(.DATA_WIDTH(64), .ID_WIDTH(8), .USER_WIDTH(2)) axis_bus ();

  axis_stream_tx_fifo #(
    .DATA_WIDTH(64), .ID_WIDTH(8), .USER_WIDTH(2), .FIFO_DEPTH(4), .LEN_WIDTH(16)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .pkt_beats  (pkt_beats),
    .last_bytes (last_bytes),
    .pkt_id     (pkt_id),
    .pkt_user   (pkt_user),
    .flush      (flush),
    .in_pkt     (in_pkt),
`ifdef AXIS_TX_STATS_EN
    .pkt_count  (pkt_count),
    .stall_count(stall_count),
`endif
    .m_axis     (axis_bus)
  );

  int    check_count = 0;
  int    pass_count  = 0;
  beat_t exp_q[$];
  beat_t new_beat;
  beat_t head_beat;
  int    model_left  = 0;
  int    model_bytes = 8;
  logic [7:0] model_id;
  logic [1:0] model_user;
  logic [7:0] all_keep;
  int    exp_pkt   = 0;
  int    exp_stall = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Reference model: counts remaining beats down from the latched length.
  always @(negedge ACLK) begin
    if (!ARESETn || flush) begin
      exp_q.delete();
      model_left = 0;
      exp_pkt    = 0;
      exp_stall  = 0;
    end else begin
      if (axis_bus.TVALID && axis_bus.TREADY) begin
        checkOutput("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          head_beat = exp_q.pop_front();
          checkOutput("tdata", axis_bus.TDATA, head_beat.data);
          checkOutput("tkeep", 64'(axis_bus.TKEEP), 64'(head_beat.keep));
          checkOutput("tstrb", 64'(axis_bus.TSTRB), 64'(head_beat.keep));
          checkOutput("tlast", 64'(axis_bus.TLAST), 64'(head_beat.last));
          checkOutput("tid", 64'(axis_bus.TID), 64'(head_beat.id));
          checkOutput("tuser", 64'(axis_bus.TUSER), 64'(head_beat.user));
          if (head_beat.last) exp_pkt++;
        end
      end
      if (axis_bus.TVALID && !axis_bus.TREADY) exp_stall++;
      if (in_valid && in_ready) begin
        if (model_left == 0) begin
          model_left  = (pkt_beats == 16'd0) ? 1 : int'(pkt_beats);
          model_bytes = ((last_bytes == 4'd0) || (last_bytes > 4'd8)) ? 8 : int'(last_bytes);
          model_id    = pkt_id;
          model_user  = pkt_user;
        end
        all_keep      = 8'hFF;
        new_beat.data = in_data;
        new_beat.last = (model_left == 1);
        new_beat.keep = new_beat.last ? (all_keep >> (8 - model_bytes)) : all_keep;
        new_beat.id   = model_id;
        new_beat.user = model_user;
        model_left--;
        exp_q.push_back(new_beat);
      end
    end
  end

  // Offers one beat and holds it until accepted; returns one tick after the accepting edge.
  task automatic applyStimulus(input logic [63:0] data);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    for (int i = 0; i < 40 && !accepted; i++) begin
      accepted = in_ready;
      @(posedge ACLK);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_in_time", 64'(accepted), 64'd1);
  endtask

  task automatic waitDrain();
    logic drained;
    drained = 1'b0;
    for (int i = 0; i < 60 && !drained; i++) begin
      if (exp_q.size() == 0 && !axis_bus.TVALID) drained = 1'b1;
      else begin
        @(posedge ACLK);
        #1;
      end
    end
    checkOutput("drain_done", 64'(drained), 64'd1);
  endtask

  task automatic setPacket(input logic [15:0] beats, input logic [3:0] bytes,
                           input logic [7:0] id, input logic [1:0] user);
    pkt_beats  = beats;
    last_bytes = bytes;
    pkt_id     = id;
    pkt_user   = user;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ARESETn         = 1'b1;
    in_valid        = 1'b0;
    in_data         = '0;
    flush           = 1'b0;
    axis_bus.TREADY = 1'b0;
    setPacket(16'd1, 4'd0, 8'h00, 2'd0);
    #1 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #2 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    checkOutput("rst_tvalid", 64'(axis_bus.TVALID), 64'd0);
    checkOutput("rst_tdata", axis_bus.TDATA, 64'd0);
    checkOutput("rst_tkeep", 64'(axis_bus.TKEEP), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_in_pkt", 64'(in_pkt), 64'd0);

    $display("[TB] framing: 3 beats, 5 bytes in last beat");
    axis_bus.TREADY = 1'b1;
    setPacket(16'd3, 4'd5, 8'h2A, 2'd1);
    applyStimulus(64'd1);
    checkOutput("frame_in_pkt_mid", 64'(in_pkt), 64'd1);
    setPacket(16'd9, 4'd2, 8'hFF, 2'd3);
    applyStimulus(64'd2);
    applyStimulus(64'd3);
    checkOutput("frame_in_pkt_end", 64'(in_pkt), 64'd0);
    waitDrain();

    $display("[TB] single-beat and zero-length packets");
    setPacket(16'd0, 4'd0, 8'h11, 2'd2);
    applyStimulus(64'hA);
    checkOutput("zero_len_idle", 64'(in_pkt), 64'd0);
    setPacket(16'd1, 4'd0, 8'h12, 2'd0);
    applyStimulus(64'hB);
    checkOutput("one_len_idle", 64'(in_pkt), 64'd0);
    setPacket(16'd1, 4'd9, 8'h13, 2'd1);
    applyStimulus(64'hC);
    setPacket(16'd1, 4'd3, 8'h14, 2'd3);
    applyStimulus(64'hD);
    waitDrain();

    $display("[TB] backpressure with 5 beats into depth 4");
    axis_bus.TREADY = 1'b0;
    setPacket(16'd5, 4'd3, 8'h33, 2'd2);
    applyStimulus(64'h100);
    checkOutput("latency_tvalid", 64'(axis_bus.TVALID), 64'd1);
    for (int i = 1; i < 4; i++) applyStimulus(64'h100 + 64'(i));
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = 64'h104;
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK);
      #1;
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_tvalid", 64'(axis_bus.TVALID), 64'd1);
      checkOutput("stall_tdata", axis_bus.TDATA, 64'h100);
    end
`ifdef AXIS_TX_STATS_EN
    checkOutput("stall_count", 64'(stall_count), 64'(exp_stall));
`endif
    axis_bus.TREADY = 1'b1;
    #1;
    checkOutput("no_ready_path", 64'(in_ready), 64'd0);
    applyStimulus(64'h104);
    waitDrain();

    $display("[TB] flush with 2 beats queued");
    axis_bus.TREADY = 1'b0;
    setPacket(16'd4, 4'd8, 8'h44, 2'd1);
    applyStimulus(64'h200);
    applyStimulus(64'h201);
    checkOutput("pre_flush_in_pkt", 64'(in_pkt), 64'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h202;
    @(posedge ACLK);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_tvalid", 64'(axis_bus.TVALID), 64'd0);
    checkOutput("flush_in_pkt", 64'(in_pkt), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef AXIS_TX_STATS_EN
    checkOutput("flush_stall_count", 64'(stall_count), 64'd0);
`endif
    axis_bus.TREADY = 1'b1;
    setPacket(16'd2, 4'd2, 8'h55, 2'd3);
    applyStimulus(64'h300);
    applyStimulus(64'h301);
    waitDrain();

    $display("[TB] four 2-beat packets back to back");
    for (int p = 0; p < 4; p++) begin
      setPacket(16'd2, 4'(p + 1), 8'(8'h60 + p), 2'(p));
      for (int b = 0; b < 2; b++) begin
        checkOutput("throughput_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(64'h400 + 64'(p * 2 + b));
      end
    end
    waitDrain();
`ifdef AXIS_TX_STATS_EN
    checkOutput("pkt_count", 64'(pkt_count), 64'(exp_pkt));
    checkOutput("pkt_count_abs", 64'(pkt_count), 64'd5);
`endif

    $display("[TB] reset mid-packet with 3 beats buffered");
    axis_bus.TREADY = 1'b0;
    setPacket(16'd6, 4'd4, 8'h77, 2'd2);
    for (int i = 0; i < 3; i++) applyStimulus(64'h500 + 64'(i));
    #2 ARESETn = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid", 64'(axis_bus.TVALID), 64'd0);
    checkOutput("mid_rst_tdata", axis_bus.TDATA, 64'd0);
    checkOutput("mid_rst_tkeep", 64'(axis_bus.TKEEP), 64'd0);
    checkOutput("mid_rst_tstrb", 64'(axis_bus.TSTRB), 64'd0);
    checkOutput("mid_rst_tlast", 64'(axis_bus.TLAST), 64'd0);
    checkOutput("mid_rst_tid", 64'(axis_bus.TID), 64'd0);
    checkOutput("mid_rst_tuser", 64'(axis_bus.TUSER), 64'd0);
    checkOutput("mid_rst_in_pkt", 64'(in_pkt), 64'd0);
    repeat (2) @(posedge ACLK);
    #2 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("post_rst_tvalid", 64'(axis_bus.TVALID), 64'd0);
    axis_bus.TREADY = 1'b1;
    setPacket(16'd2, 4'd7, 8'h88, 2'd1);
    applyStimulus(64'h600);
    applyStimulus(64'h601);
    waitDrain();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
